serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Parametrised bit-serial subtractor computing a − b − bin over WIDTH-bit operands. Uses one full-subtractor cell per clock and produces WIDTH difference bits plus borrow-out after WIDTH cycles. Has a start/busy/done handshake and a borrow-chaining mode, so wider words can be subtracted as consecutive WIDTH-bit slices. It is the sequential, area-minimal successor to the combinational full-subtractor cell and sits in arithmetic datapaths where throughput is not critical.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request an operation; sampled on clk rising edge
- chain  input  1  0: borrow-in taken from bin; 1: borrow-in = stored bout of previous completed operation
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  external borrow-in; captured when start is accepted
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse: diff/bout valid
- diff  output  WIDTH  difference a − b − borrow-in, modulo 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + borrow-in (unsigned)

## Operation
- States: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE and ignored in RUN.
- On accept:
  - sh_a ← a, sh_b ← b, cnt ← 0.
  - br ← (chain ? bout : bin).
  - diff shift register is cleared to 0.
  - State goes to RUN.
- RUN, each cycle, using LSBs a0 = sh_a[0], b0 = sh_b[0]:
  - d = a0 ^ b0 ^ br
  - br ← (~a0 & b0) | (~(a0 ^ b0) & br)
  - diff ← {d, diff[WIDTH-1:1]}
  - sh_a and sh_b shift right by one; cnt ← cnt + 1.
- Leaving RUN: when cnt == WIDTH−1, that cycle's update is the last one.
  - State → DONE, bout ← final br, done ← 1.
- DONE lasts one cycle, then IDLE unless start is accepted again.
- diff and bout hold their values until the next accepted start. At that start diff is cleared; bout holds, because it is the chain source.
- cnt width is $clog2(WIDTH+1). WIDTH = 1 is legal: RUN lasts exactly one cycle.
- Reset at any point, including mid-RUN:
  - state IDLE; busy, done, diff, bout all 0.
  - Stored chain borrow is 0; no done pulse is produced for the aborted operation.
- If start and chain are both 1 right after reset, borrow-in is 0.

## Timing
- Start accepted at edge E0. Bits are processed at edges E1..E_WIDTH.
- done is high for the cycle following edge E_WIDTH, i.e. latency is WIDTH cycles from the accepting edge.
- busy is high from after E0 until edge E_WIDTH.
- Back-to-back: start high during the DONE cycle is accepted. Throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Changing a/b/bin/chain after the accepting edge has no effect on the operation in flight.

## Structure
- Package serial_subtractor_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - the localparam CNT_W function ($clog2 helper).
- Sub-module fs_cell: combinational 1-bit full subtractor (a, b, bi → d, bo), instantiated once on the shift-register LSBs.
- The rest is a single always_ff process for state, shift registers, counter and borrow register, with async reset.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0, chain=0 → done exactly 8 cycles after the accepting edge, diff=0x02, bout=0; busy high for 8 cycles.
- WIDTH=8, a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Chain, 16-bit 0x0100 − 0x0001 as two WIDTH=8 slices:
  - low slice a=0x00, b=0x01, chain=0 → diff=0xFF, bout=1.
  - high slice a=0x01, b=0x00, chain=1 → diff=0x00, bout=0.
- Start pulsed again 3 cycles into RUN with different operands → ignored. Result matches the first operands; exactly one done pulse.
- Assert rst 4 cycles into RUN → busy, done, diff, bout go to 0 immediately. No done appears afterwards. Next chain=1 operation uses borrow-in 0.
- WIDTH=1, all 8 (a, b, bin) combinations, chain=0 → (diff, bout) = 00, 11, 11, 01, 10, 00, 00, 11 in order 000..111. Each done arrives 1 cycle after accept; back-to-back starts issued in DONE are all accepted.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// No logic; no latency; no backpressure.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
// Zero latency; no backpressure.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in over WIDTH bits, one bit per clock, borrow-chainable.
// Latency WIDTH cycles from accepting edge to done; start is ignored while busy.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chain,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] diff_nxt;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             d;
    logic             bo;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    fs_cell u_fs_cell (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // New bit enters at the MSB so the first processed bit ends up at bit 0.
    always_comb begin
        diff_nxt            = diff >> 1;
        diff_nxt[WIDTH-1]   = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sh_a <= a;
                sh_b <= b;
                cnt  <= '0;
                br   <= chain ? bout : bin;
                diff <= '0;
            end else if (state == RUN) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                cnt  <= cnt + 1'b1;
                br   <= bo;
                diff <= diff_nxt;
                if (last) bout <= bo;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances, vector table, corner sequences, random ops.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 0, chain8 = 0, bin8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1 = 0, chain1 = 0, bin1 = 0;
    logic [0:0] a1 = 0, b1 = 0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .chain(chain8), .a(a8), .b(b8),
        .bin(bin8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .chain(chain1), .a(a1), .b(b1),
        .bin(bin1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    int total = 0;
    int bad   = 0;
    logic model_bout = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic       chain;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: unsigned subtraction one bit wider; the extra bit is the borrow.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic br);
        return {1'b0, x} - {1'b0, y} - {8'b0, br};
    endfunction

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, input logic ichain,
                       output logic [7:0] od, output logic ob, output int lat, output int bsy);
        a8 = ia; b8 = ib; bin8 = ibin; chain8 = ichain; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); chain8 = 1'($urandom);
        bsy = busy8 ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k;
                break;
            end
            if (busy8) bsy++;
        end
        od = diff8;
        ob = bout8;
    endtask

    task automatic run8(input string nm, input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        input logic ichain, input logic [7:0] ed, input logic eb);
        logic [7:0] d;
        logic       bo;
        int         lat, bsy;
        op8(ia, ib, ibin, ichain, d, bo, lat, bsy);
        chk({nm, "_lat"}, lat, 8);
        chk({nm, "_busy"}, bsy, 8);
        chk({nm, "_diff"}, d, ed);
        chk({nm, "_bout"}, bo, eb);
        model_bout = eb;
    endtask

    vec_t tbl[6];
    logic [1:0] exp1 [8];

    initial begin
        logic [8:0] r;
        logic       br, cb;
        logic [7:0] rd;
        logic       rb;
        int         lat, bsy, pulses;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1};
        tbl[4] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b0};
        exp1[0] = 2'b00; exp1[1] = 2'b11; exp1[2] = 2'b11; exp1[3] = 2'b01;
        exp1[4] = 2'b10; exp1[5] = 2'b00; exp1[6] = 2'b00; exp1[7] = 2'b11;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Chain right after reset must use borrow-in 0
        run8("chain_after_rst", 8'h20, 8'h01, 1'b1, 1'b1, 8'h1F, 1'b0);

        for (int i = 0; i < 6; i++)
            run8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].chain,
                 tbl[i].exp_diff, tbl[i].exp_bout);

        // Start re-pulsed 3 cycles into RUN must be ignored
        repeat (2) @(posedge clk); #1;
        a8 = 8'h40; b8 = 8'h11; bin8 = 1'b0; chain8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (k == 3) begin
                a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
            end
            if (k == 4) start8 = 1'b0;
            if (done8) begin
                pulses++;
                if (pulses == 1) begin
                    chk("ign_lat", k, 8);
                    chk("ign_diff", diff8, 8'h2F);
                    chk("ign_bout", bout8, 0);
                end
            end
        end
        chk("ign_pulses", pulses, 1);
        model_bout = 1'b0;

        // Reset 4 cycles into RUN, with a stored borrow of 1 beforehand
        run8("pre_rst", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
        a8 = 8'h55; b8 = 8'h00; bin8 = 1'b0; chain8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_done", done8, 0);
        chk("mid_rst_diff", diff8, 0);
        chk("mid_rst_bout", bout8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_bout = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
        chk("post_rst_no_done", pulses, 0);
        run8("chain_post_rst", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b0);

        // Random back-to-back operations against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb8;
            logic       rbin, rch;
            ra = 8'($urandom); rb8 = 8'($urandom);
            rbin = 1'($urandom); rch = 1'($urandom);
            br = rch ? model_bout : rbin;
            r = ref_sub(ra, rb8, br);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
            run8($sformatf("rnd%0d", i), ra, rb8, rbin, rch, r[7:0], r[8]);
        end

        // WIDTH=1: all eight combinations back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; chain1 = 1'b0; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            cb = busy1;
            lat = -1;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                if (done1) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("w1_%0d_busy", i), cb, 1);
            chk($sformatf("w1_%0d_lat", i), lat, 1);
            chk($sformatf("w1_%0d_res", i), {diff1, bout1}, exp1[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
